// File: rtl/soc_pkg.sv
// soc_pkg: shared SoC clock/baud constants, IO status bit positions and UART receiver state encoding
package soc_pkg;
    localparam int CLK_FREQ_HZ = 100_000_000;
    localparam int BAUD_RATE   = 115_200;
    localparam int IO_BIT_LED        = 0;
    localparam int IO_BIT_BUTTON     = 1;
    localparam int IO_BIT_TX_BUSY    = 2;
    localparam int IO_STAT_RX_VALID  = 3;
    localparam int IO_STAT_OVERRUN   = 4;
    localparam int IO_STAT_FRAME_ERR = 5;
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with occupancy count and drop indication
//   clk, resetn        clock, async active-low reset
//   i_push, i_data     write request and data
//   i_pop              read request (ignored when empty)
//   o_data, o_valid    head entry (zero when empty) and not-empty flag
//   o_count            occupancy
//   o_drop             push refused because the FIFO was full and nothing was popped
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_valid,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_drop
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             empty, full, push, pop;
    always_comb begin
        empty   = cnt_q == '0;
        full    = cnt_q == (AW+1)'(DEPTH);
        pop     = i_pop && !empty;
        // a pop frees the slot the push lands in, so full+pop still accepts the write
        push    = i_push && (!full || pop);
        o_drop  = i_push && full && !pop;
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        if (push) begin
            mem_d[wr_q] = i_data;
            wr_d        = wr_q + 1'b1;
        end
        if (pop)
            rd_d = rd_q + 1'b1;
        cnt_d   = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        o_data  = empty ? '0 : mem_q[rd_q];
        o_valid = !empty;
        o_count = cnt_q;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a FWFT byte FIFO with sticky overrun/framing flags
//   clk, resetn           clock, async active-low reset
//   rxd                   asynchronous serial input, idle high
//   o_data, o_valid       FIFO head byte and not-empty flag
//   i_ready               pop request
//   o_count               FIFO occupancy
//   o_overrun             sticky: byte dropped on full FIFO
//   o_frame_err           sticky: stop bit sampled low
//   i_clr_err             clears both sticky flags (a coincident new event wins)
module uart_rx_fifo
    import soc_pkg::*;
#(
    parameter int CLK_FREQ_HZ = soc_pkg::CLK_FREQ_HZ,
    parameter int BAUD_RATE   = soc_pkg::BAUD_RATE,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        rxd,
    output logic [7:0]                  o_data,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [$clog2(FIFO_DEPTH):0] o_count,
    output logic                        o_overrun,
    output logic                        o_frame_err,
    input  logic                        i_clr_err
);
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [1:0]    sync_q, sync_d;
    logic          overrun_q, overrun_d, frame_q, frame_d;
    logic          rx, push, frame_set, drop;
    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (push),
        .i_data  (shift_q),
        .i_pop   (i_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_count (o_count),
        .o_drop  (drop)
    );
    always_comb begin
        sync_d    = {sync_q[0], rxd};
        rx        = sync_q[1];
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx) begin
                    state_d = RX_START;
                    bit_d   = '0;
                end
            end
            RX_START: begin
                // half-bit check centres later samples and rejects short glitches
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7)
                        state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    push      = rx;
                    frame_set = !rx;
                    state_d   = rx ? RX_IDLE : RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: begin
                cnt_d = '0;
                if (rx)
                    state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
        overrun_d   = (overrun_q && !i_clr_err) || drop;
        frame_d     = (frame_q && !i_clr_err) || frame_set;
        o_overrun   = overrun_q;
        o_frame_err = frame_q;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            sync_q    <= 2'b11;
            overrun_q <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            sync_q    <= sync_d;
            overrun_q <= overrun_d;
            frame_q   <= frame_d;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo at 10 clocks per bit
module tb_uart_rx_fifo;
    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int DEPTH  = 8;

    logic       clk = 1'b0, resetn = 1'b0, rxd = 1'b1, i_ready = 1'b0, i_clr_err = 1'b0;
    logic [7:0] o_data;
    logic       o_valid, o_overrun, o_frame_err;
    logic [3:0] o_count;

    int  vectors = 0, miscompares = 0;
    int  cyc = 0, rise_cyc = -1, frame_t0 = 0, lat = 98;
    byte unsigned exp_q[$];
    bit  exp_ovr = 0, exp_fe = 0;
    logic prev_valid = 1'b0;

    uart_rx_fifo #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD_RATE   (BAUD),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .rxd         (rxd),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_count     (o_count),
        .o_overrun   (o_overrun),
        .o_frame_err (o_frame_err),
        .i_clr_err   (i_clr_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // monitor: every accepted pop must match the oldest expected byte
    always @(negedge clk) begin
        if (resetn && o_valid === 1'b1 && i_ready === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL pop_data: got %02h required no byte (model empty)", o_data);
            end else begin
                if (o_data !== exp_q[0]) begin
                    miscompares++;
                    $display("FAIL pop_data: got %02h required %02h", o_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
        if (o_valid === 1'b1 && prev_valid !== 1'b1)
            rise_cyc = cyc;
        prev_valid = o_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string name);
        check({name, "_count"}, 32'(o_count), 32'(exp_q.size()));
        check({name, "_valid"}, 32'(o_valid), 32'(exp_q.size() != 0));
        check({name, "_overrun"}, 32'(o_overrun), 32'(exp_ovr));
        check({name, "_frame_err"}, 32'(o_frame_err), 32'(exp_fe));
    endtask

    task automatic clr_err();
        i_clr_err = 1'b1;
        tick();
        i_clr_err = 1'b0;
        exp_ovr = 0;
        exp_fe = 0;
    endtask

    // full 8N1 frame; the model decides acceptance at the start of the stop bit
    task automatic send_frame(input byte unsigned d, input bit stop,
                              input bit pop_at_push = 0, input bit clr_at_sample = 0);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        @(posedge clk);
        #1;
        frame_t0 = cyc;
        for (int k = 0; k < 10 * CPB; k++) begin
            rxd = bits[k / CPB];
            if (k == 9 * CPB) begin
                if (!stop)
                    exp_fe = 1;
                else if (exp_q.size() < DEPTH || pop_at_push)
                    exp_q.push_back(d);
                else
                    exp_ovr = 1;
            end
            if (k == lat - 1) begin
                if (pop_at_push) i_ready = 1'b1;
                if (clr_at_sample) i_clr_err = 1'b1;
            end
            if (k == lat) begin
                if (pop_at_push) i_ready = 1'b0;
                i_clr_err = 1'b0;
            end
            tick();
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        i_ready = 1'b1;
        while (o_valid === 1'b1 && n < 4 * DEPTH) begin
            tick();
            n++;
        end
        i_ready = 1'b0;
        vectors++;
        if (n >= 4 * DEPTH) begin
            miscompares++;
            $display("FAIL %s_timeout: got %0d cycles required fewer than %0d", name, n, 4 * DEPTH);
        end
        check({name, "_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_count"}, 32'(o_count), 32'd0);
        check({name, "_valid"}, 32'(o_valid), 32'd0);
        check({name, "_data"}, 32'(o_data), 32'd0);
    endtask

    initial begin
        int meas;
        logic [9:0] cbits;
        byte unsigned d;
        tick(3);
        check("reset_valid", 32'(o_valid), 0);
        check("reset_data", 32'(o_data), 0);
        check("reset_count", 32'(o_count), 0);
        check("reset_overrun", 32'(o_overrun), 0);
        check("reset_frame_err", 32'(o_frame_err), 0);
        resetn = 1'b1;
        tick(5);

        // single byte and push latency
        rise_cyc = -1;
        send_frame(8'h55, 1'b1);
        meas = rise_cyc - frame_t0;
        vectors++;
        if (rise_cyc < 0 || meas < 9 * CPB + 1 || meas > 10 * CPB) begin
            miscompares++;
            $display("FAIL push_latency: got %0d cycles required within stop bit %0d..%0d", meas, 9 * CPB + 1, 10 * CPB);
        end else
            lat = meas;
        check("b55_data", 32'(o_data), 32'h55);
        check_model("b55");
        drain("b55_drain");

        // overrun
        for (int i = 1; i <= 9; i++)
            send_frame(byte'(i), 1'b1);
        tick(2);
        check("ovr_count8", 32'(o_count), 8);
        check("ovr_flag", 32'(o_overrun), 1);
        check_model("ovr");
        drain("ovr_drain");
        clr_err();
        check_model("ovr_clr");

        // framing error, wait-high hold, recovery
        send_frame(8'hA5, 1'b0);
        tick(2);
        check("fe_flag", 32'(o_frame_err), 1);
        check_model("fe");
        tick(50);
        check_model("fe_hold_low");
        rxd = 1'b1;
        tick(20);
        check_model("fe_line_high");
        clr_err();
        send_frame(8'h3C, 1'b1);
        tick(2);
        check_model("fe_recover");
        drain("fe_drain");

        // clear coinciding with a new framing error: set wins
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        tick(2);
        check("setwins_frame_err", 32'(o_frame_err), 1);
        rxd = 1'b1;
        tick(20);
        clr_err();
        check_model("setwins_clr");

        // short glitch on idle line
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(20);
        check_model("glitch");

        // full FIFO with push and pop together
        for (int i = 0; i < DEPTH; i++)
            send_frame(byte'($urandom), 1'b1);
        send_frame(8'hE7, 1'b1, 1'b1);
        tick(2);
        check("pp_count8", 32'(o_count), 8);
        check("pp_overrun", 32'(o_overrun), 0);
        check_model("pp");
        drain("pp_drain");

        // reset in the middle of 0xC3, with a stale byte already buffered
        send_frame(8'hA0, 1'b1);
        cbits = {1'b1, 8'hC3, 1'b0};
        for (int k = 0; k < 5 * CPB + CPB / 2; k++) begin
            rxd = cbits[k / CPB];
            tick();
        end
        resetn = 1'b0;
        exp_q.delete();
        exp_ovr = 0;
        exp_fe = 0;
        tick(3);
        check("midrst_count", 32'(o_count), 0);
        check("midrst_data", 32'(o_data), 0);
        rxd = 1'b1;
        resetn = 1'b1;
        tick(20);
        check_model("midrst_idle");
        send_frame(8'h7E, 1'b1);
        tick(2);
        check("midrst_7e_count", 32'(o_count), 1);
        check_model("midrst_7e");
        drain("midrst_drain");

        // random traffic with partial drains
        for (int f = 0; f < 25; f++) begin
            d = byte'($urandom);
            send_frame(d, 1'b1);
            tick($urandom_range(0, 5));
            if ($urandom_range(0, 1) == 1) begin
                i_ready = 1'b1;
                tick($urandom_range(1, 4));
                i_ready = 1'b0;
            end
            tick();
            check_model("rand");
            if (exp_ovr) clr_err();
        end
        drain("rand_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
